// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 encryptor.
// Holds the FSM state enum, the forward S-box, the round count, the
// GF(2^8) reduction polynomial and the xtime helper.
package aes_pkg;

  localparam int         NR      = 10;
  localparam logic [8:0] GF_POLY = 9'h11B;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsmState_e;

  // Index 0 is the leftmost entry so the table reads like FIPS-197.
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8), reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round:
// stateOut = AddRoundKey(MixColumns(ShiftRows(SubBytes(stateIn))), roundKey),
// MixColumns bypassed when lastRound is high.
// Ports: stateIn[127:0], roundKey[127:0], lastRound -> stateOut[127:0].
// Byte b = 4*col + row sits at bits [127-8b -: 8].
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] stateIn,
  input  logic [127:0] roundKey,
  input  logic         lastRound,
  output logic [127:0] stateOut
);

  logic [7:0] sb [4][4];  // [col][row] after SubBytes
  logic [7:0] sr [4][4];  // after ShiftRows
  logic [7:0] mc [4][4];  // after MixColumns

  for (genvar c = 0; c < 4; c++) begin : gCol
    for (genvar r = 0; r < 4; r++) begin : gRow
      assign sb[c][r] = SBOX[stateIn[127-8*(4*c+r) -: 8]];
      // Row r rotates left by r: column c takes from column c+r.
      assign sr[c][r] = sb[(c+r)%4][r];
    end

    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[c][0];
    assign a1 = sr[c][1];
    assign a2 = sr[c][2];
    assign a3 = sr[c][3];

    // 3*a == xtime(a) ^ a
    assign mc[c][0] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[c][1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[c][2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[c][3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

    for (genvar r = 0; r < 4; r++) begin : gOut
      assign stateOut[127-8*(4*c+r) -: 8] =
        (lastRound ? sr[c][r] : mc[c][r]) ^ roundKey[127-8*(4*c+r) -: 8];
    end
  end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor, one round per clock, round keys supplied
// externally via roundIdx/roundKey. 10-cycle latency from input handshake
// to outValid; result held until outReady.
// Ports: clk, rst_n (async low), inValid/inReady/dataIn (plaintext),
// roundIdx/roundKey (key lookup), outValid/outReady/dataOut (ciphertext).
// Build option: AES_ENC_ZEROIZE_EN clears the state register on the
// output handshake so no ciphertext lingers in IDLE.
module aes_enc_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] dataIn,
  output logic [3:0]   roundIdx,
  input  logic [127:0] roundKey,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] dataOut
);

  fsmState_e    fsmQ, fsmD;
  logic [3:0]   cntQ, cntD;
  logic [127:0] stQ, stD, roundOut;
  logic         lastRound;

  assign lastRound = (cntQ == 4'(NR));
  assign dataOut   = stQ;

  aes_enc_round uRound (
    .stateIn  (stQ),
    .roundKey (roundKey),
    .lastRound(lastRound),
    .stateOut (roundOut)
  );

  always_comb begin
    fsmD     = fsmQ;
    cntD     = cntQ;
    stD      = stQ;
    inReady  = 1'b0;
    outValid = 1'b0;
    roundIdx = 4'd0;
    case (fsmQ)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) begin
          stD  = dataIn ^ roundKey;  // initial AddRoundKey with key 0
          cntD = 4'd1;
          fsmD = BUSY;
        end
      end
      BUSY: begin
        roundIdx = cntQ;
        stD      = roundOut;
        cntD     = cntQ + 4'd1;
        if (lastRound) begin
          cntD = 4'd0;
          fsmD = DONE;
        end
      end
      DONE: begin
        outValid = 1'b1;
        if (outReady) begin
          fsmD = IDLE;
`ifdef AES_ENC_ZEROIZE_EN
          stD  = '0;
`else
          stD  = stQ;
`endif
        end
      end
      default: fsmD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsmQ <= IDLE;
      cntQ <= 4'd0;
      stQ  <= '0;
    end else begin
      fsmQ <= fsmD;
      cntQ <= cntD;
      stQ  <= stD;
    end
  end

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed bench for aes_enc_iter: FIPS-197 App. B and C.1 vectors,
// roundIdx sequencing, backpressure, mid-block reset and idle dataOut
// in both builds (AES_ENC_ZEROIZE_EN defined or not).
module tb_aes_enc_iter;
  import aes_pkg::*;

  typedef logic [0:10][127:0] rks_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         inValid, inReady, outValid, outReady;
  logic [127:0] dataIn, roundKey, dataOut;
  logic [3:0]   roundIdx;
  rks_t         rk;
  int           total = 0;
  int           bad   = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

`ifdef AES_ENC_ZEROIZE_EN
  localparam logic [127:0] IDLE_B = 128'h0;
`else
  localparam logic [127:0] IDLE_B = CT_B;
`endif

  always #5 clk = ~clk;

  aes_enc_iter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .inValid (inValid),
    .inReady (inReady),
    .dataIn  (dataIn),
    .roundIdx(roundIdx),
    .roundKey(roundKey),
    .outValid(outValid),
    .outReady(outReady),
    .dataOut (dataOut)
  );

  always_comb begin
    roundKey = '0;
    if (int'(roundIdx) <= 10) roundKey = rk[int'(roundIdx)];
  end

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Standard AES-128 key schedule.
  function automatic rks_t expandKey(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rks_t        res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) res[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic         sawValid;
  logic [127:0] held;

  initial begin
    rst_n    = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b0;
    dataIn   = '0;
    rk       = expandKey(KEY_B);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_inReady",  128'(inReady),  128'(1));
    chk("rst_outValid", 128'(outValid), 128'(0));
    chk("rst_dataOut",  dataOut,        128'h0);
    chk("rst_roundIdx", 128'(roundIdx), 128'(0));
    rst_n = 1'b1;

    // App. B: handshake on the first edge after release, noisy dataIn/inValid in BUSY
    inValid = 1'b1;
    dataIn  = PT_B;
    chk("B_idleIdx", 128'(roundIdx), 128'(0));
    step();
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("B_idx%0d", i), 128'(roundIdx), 128'(i));
      chk($sformatf("B_busyOv%0d", i), 128'({inReady, outValid}), 128'(0));
      dataIn = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    chk("B_outValid", 128'(outValid), 128'(1));
    chk("B_dataOut",  dataOut,        CT_B);
    chk("B_doneIdx",  128'(roundIdx), 128'(0));

    // Backpressure: 5 cycles in DONE with inValid held high
    held = dataOut;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp_ov%0d", i),   128'(outValid), 128'(1));
      chk($sformatf("bp_ir%0d", i),   128'(inReady),  128'(0));
      chk($sformatf("bp_data%0d", i), dataOut,        held);
    end
    rk       = expandKey(KEY_C);
    dataIn   = PT_C;
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    chk("hs_outValid", 128'(outValid), 128'(0));
    chk("hs_inReady",  128'(inReady),  128'(1));
    chk("hs_idleData", dataOut,        IDLE_B);

    // App. C.1 accepted exactly one cycle after the output handshake
    step();
    inValid = 1'b0;
    chk("C_inReady", 128'(inReady), 128'(0));
    for (int i = 1; i <= 10; i++) begin
      chk($sformatf("C_idx%0d", i), 128'(roundIdx), 128'(i));
      step();
    end
    chk("C_outValid", 128'(outValid), 128'(1));
    chk("C_dataOut",  dataOut,        CT_C);
    outReady = 1'b1;
    step();
    outReady = 1'b0;

    // Reset at BUSY counter=5
    rk      = expandKey(KEY_B);
    inValid = 1'b1;
    dataIn  = PT_B;
    step();
    inValid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mr_idx5", 128'(roundIdx), 128'(5));
    rst_n = 1'b0;
    #1;
    chk("mr_dataOut",  dataOut,        128'h0);
    chk("mr_inReady",  128'(inReady),  128'(1));
    chk("mr_roundIdx", 128'(roundIdx), 128'(0));
    @(negedge clk);
    rst_n    = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (outValid) sawValid = 1'b1;
      step();
    end
    chk("mr_noPulse",  128'(sawValid), 128'(0));
    chk("mr_dataOut2", dataOut,        128'h0);

    // Fresh App. B after the aborted block
    inValid = 1'b1;
    dataIn  = PT_B;
    step();
    inValid = 1'b0;
    for (int i = 0; i < 9; i++) step();
    chk("B2_preValid", 128'(outValid), 128'(0));
    step();
    chk("B2_outValid", 128'(outValid), 128'(1));
    chk("B2_dataOut",  dataOut,        CT_B);
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    chk("B2_idleData", dataOut, IDLE_B);
    step();
    step();
    chk("B2_idleHold", dataOut,        IDLE_B);
    chk("B2_idleOv",   128'(outValid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
